wfg_wb_arbiter: RTL and testbench

//  Two-master, one-slave Wishbone classic arbiter for the SoC peripheral bus.

---
 rtl/wfg_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wfg_wb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wfg_wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant
// and a stall watchdog that force-terminates cycles a slave never acks.
module wfg_wb_arbiter #(
   parameter int unsigned            ADDR_WIDTH   = 32,
   parameter int unsigned            DATA_WIDTH   = 32,
   parameter int unsigned            TIMEOUT      = 16,
   parameter logic [DATA_WIDTH-1:0]  TIMEOUT_DATA = DATA_WIDTH'(32'hDEADBEEF)
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      m0_wb_cyc_i,
   input  logic                      m0_wb_stb_i,
   input  logic                      m0_wb_we_i,
   input  logic [DATA_WIDTH/8-1:0]   m0_wb_sel_i,
   input  logic [ADDR_WIDTH-1:0]     m0_wb_adr_i,
   input  logic [DATA_WIDTH-1:0]     m0_wb_dat_i,
   output logic [DATA_WIDTH-1:0]     m0_wb_dat_o,
   output logic                      m0_wb_ack_o,

   input  logic                      m1_wb_cyc_i,
   input  logic                      m1_wb_stb_i,
   input  logic                      m1_wb_we_i,
   input  logic [DATA_WIDTH/8-1:0]   m1_wb_sel_i,
   input  logic [ADDR_WIDTH-1:0]     m1_wb_adr_i,
   input  logic [DATA_WIDTH-1:0]     m1_wb_dat_i,
   output logic [DATA_WIDTH-1:0]     m1_wb_dat_o,
   output logic                      m1_wb_ack_o,

   output logic                      s_wb_cyc_o,
   output logic                      s_wb_stb_o,
   output logic                      s_wb_we_o,
   output logic [DATA_WIDTH/8-1:0]   s_wb_sel_o,
   output logic [ADDR_WIDTH-1:0]     s_wb_adr_o,
   output logic [DATA_WIDTH-1:0]     s_wb_dat_o,
   input  logic [DATA_WIDTH-1:0]     s_wb_dat_i,
   input  logic                      s_wb_ack_i,

   output logic [1:0]                grant_o,
   output logic                      timeout_o,
   output logic [7:0]                timeout_cnt_o
);

   localparam int unsigned SEL_W = DATA_WIDTH / 8;
   localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

   state_t          state;
   logic            owner;      // master that holds (or held, in ABORT) the bus
   logic            last;       // most recently granted master
   logic [WD_W-1:0] wd_cnt;
   logic            owner_cyc_c;
   logic            wd_expire_c;

   assign owner_cyc_c = owner ? m1_wb_cyc_i : m0_wb_cyc_i;

   // Slave-side mux and response routing, driven from the registered state.
   always_comb begin
      s_wb_cyc_o  = 1'b0;
      s_wb_stb_o  = 1'b0;
      s_wb_we_o   = 1'b0;
      s_wb_sel_o  = '0;
      s_wb_adr_o  = '0;
      s_wb_dat_o  = '0;
      m0_wb_ack_o = 1'b0;
      m0_wb_dat_o = '0;
      m1_wb_ack_o = 1'b0;
      m1_wb_dat_o = '0;
      wd_expire_c = 1'b0;
      case (state)
         OWN0: begin
            s_wb_cyc_o  = m0_wb_cyc_i;
            s_wb_stb_o  = m0_wb_cyc_i & m0_wb_stb_i;
            s_wb_we_o   = m0_wb_we_i;
            s_wb_sel_o  = SEL_W'(m0_wb_sel_i);
            s_wb_adr_o  = m0_wb_adr_i;
            s_wb_dat_o  = m0_wb_dat_i;
            m0_wb_ack_o = s_wb_ack_i & m0_wb_cyc_i & m0_wb_stb_i;
            m0_wb_dat_o = s_wb_dat_i;
         end
         OWN1: begin
            s_wb_cyc_o  = m1_wb_cyc_i;
            s_wb_stb_o  = m1_wb_cyc_i & m1_wb_stb_i;
            s_wb_we_o   = m1_wb_we_i;
            s_wb_sel_o  = SEL_W'(m1_wb_sel_i);
            s_wb_adr_o  = m1_wb_adr_i;
            s_wb_dat_o  = m1_wb_dat_i;
            m1_wb_ack_o = s_wb_ack_i & m1_wb_cyc_i & m1_wb_stb_i;
            m1_wb_dat_o = s_wb_dat_i;
         end
         ABORT: begin
            if (owner) begin
               m1_wb_ack_o = 1'b1;
               m1_wb_dat_o = TIMEOUT_DATA;
            end else begin
               m0_wb_ack_o = 1'b1;
               m0_wb_dat_o = TIMEOUT_DATA;
            end
         end
         default: ;
      endcase
      // A slave ack in the expiry cycle takes priority over the abort.
      wd_expire_c = (TIMEOUT != 0) && s_wb_stb_o && !s_wb_ack_i &&
                    (wd_cnt == WD_W'(TIMEOUT - 1));
   end

   // Arbitration FSM, watchdog and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last          <= 1'b1;
         wd_cnt        <= '0;
         grant_o       <= 2'b00;
         timeout_o     <= 1'b0;
         timeout_cnt_o <= 8'd0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               wd_cnt <= '0;
               if (m0_wb_cyc_i && (!m1_wb_cyc_i || last)) begin
                  state   <= OWN0;
                  owner   <= 1'b0;
                  last    <= 1'b0;
                  grant_o <= 2'b01;
               end else if (m1_wb_cyc_i) begin
                  state   <= OWN1;
                  owner   <= 1'b1;
                  last    <= 1'b1;
                  grant_o <= 2'b10;
               end
            end
            OWN0, OWN1: begin
               if (!owner_cyc_c) begin
                  state   <= IDLE;
                  wd_cnt  <= '0;
                  grant_o <= 2'b00;
               end else if (wd_expire_c) begin
                  state     <= ABORT;
                  wd_cnt    <= '0;
                  timeout_o <= 1'b1;
                  if (timeout_cnt_o != 8'hFF)
                     timeout_cnt_o <= timeout_cnt_o + 8'd1;
               end else if (s_wb_ack_i) begin
                  wd_cnt <= '0;
               end else if (s_wb_stb_o) begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            ABORT: begin
               wd_cnt <= '0;
               if (owner_cyc_c) begin
                  state <= owner ? OWN1 : OWN0;
               end else begin
                  state   <= IDLE;
                  grant_o <= 2'b00;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wfg_wb_arbiter.sv
// Directed bench for wfg_wb_arbiter: the slave side is driven by hand and
// each step is checked against hand-computed values.
module tb_wfg_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_cyc, m0_stb, m0_we;
   logic [3:0]  m0_sel;
   logic [31:0] m0_adr, m0_wdat, m0_rdat;
   logic        m0_ack;
   logic        m1_cyc, m1_stb, m1_we;
   logic [3:0]  m1_sel;
   logic [31:0] m1_adr, m1_wdat, m1_rdat;
   logic        m1_ack;
   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_wdat, s_rdat;
   logic        s_ack;
   logic [1:0]  grant;
   logic        tmo;
   logic [7:0]  tmo_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wfg_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
      .m0_wb_sel_i(m0_sel), .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat),
      .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack),
      .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
      .m1_wb_sel_i(m1_sel), .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat),
      .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack),
      .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
      .s_wb_sel_o(s_sel), .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat),
      .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack),
      .grant_o(grant), .timeout_o(tmo), .timeout_cnt_o(tmo_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed hang expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_adr = '0; m0_wdat = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_adr = '0; m1_wdat = '0;
      s_rdat = '0; s_ack = 0;
      tick(); tick();
      rst = 1'b0;
      #1;
      // reset state
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_s_cyc", 32'(s_cyc), 32'h0);
      chk("rst_s_stb", 32'(s_stb), 32'h0);
      chk("rst_m0_ack", 32'(m0_ack), 32'h0);
      chk("rst_m0_dat", m0_rdat, 32'h0);
      chk("rst_tmo", 32'(tmo), 32'h0);
      chk("rst_tmo_cnt", 32'(tmo_cnt), 32'h0);

      // 1: single write from m0, slave acks on the third owned cycle
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h000E0004; m0_wdat = 32'h5;
      #1;
      chk("t1_stb_req_cycle", 32'(s_stb), 32'h0);
      tick(); #1;
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_s_stb", 32'(s_stb), 32'h1);
      chk("t1_s_adr", s_adr, 32'h000E0004);
      chk("t1_s_dat", s_wdat, 32'h5);
      chk("t1_s_we", 32'(s_we), 32'h1);
      chk("t1_ack_early", 32'(m0_ack), 32'h0);
      tick(); #1;
      chk("t1_ack_wait", 32'(m0_ack), 32'h0);
      tick(); s_ack = 1; #1;
      chk("t1_m0_ack", 32'(m0_ack), 32'h1);
      chk("t1_m1_ack", 32'(m1_ack), 32'h0);
      tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
      chk("t1_s_cyc_drop", 32'(s_cyc), 32'h0);
      chk("t1_grant_hold", 32'(grant), 32'h1);
      tick(); #1;
      chk("t1_grant_idle", 32'(grant), 32'h0);

      // 2: simultaneous request straight after reset
      rst = 1; tick();
      rst = 0;
      m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h000E0010;
      m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h000E0020;
      #1;
      chk("t2_grant_idle", 32'(grant), 32'h0);
      tick(); s_ack = 1; s_rdat = 32'hA5A5_0001; #1;
      chk("t2_grant_m0", 32'(grant), 32'h1);
      chk("t2_s_adr_m0", s_adr, 32'h000E0010);
      chk("t2_m0_dat", m0_rdat, 32'hA5A5_0001);
      chk("t2_m1_ack", 32'(m1_ack), 32'h0);
      chk("t2_m1_dat", m1_rdat, 32'h0);
      tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
      chk("t2_m1_ack_rel", 32'(m1_ack), 32'h0);
      tick(); #1;
      chk("t2_grant_gap", 32'(grant), 32'h0);
      tick(); s_ack = 1; s_rdat = 32'hA5A5_0002; #1;
      chk("t2_grant_m1", 32'(grant), 32'h2);
      chk("t2_s_adr_m1", s_adr, 32'h000E0020);
      chk("t2_m1_ack", 32'(m1_ack), 32'h1);
      chk("t2_m0_ack", 32'(m0_ack), 32'h0);
      tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0; #1;
      tick(); #1;

      // 3: round robin, both masters re-requesting after every access
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         chk($sformatf("t3_grant_%0d", i), 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
         s_ack = 1; #1;
         chk($sformatf("t3_ack_%0d", i), 32'({m1_ack, m0_ack}), (i % 2 == 0) ? 32'h1 : 32'h2);
         tick(); s_ack = 0;
         if (i % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
         else begin m1_cyc = 0; m1_stb = 0; end
         #1;
         tick();
         m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
         #1;
      end
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick(); tick(); #1;

      // 4: locked three-read burst on m0 while m1 waits
      m0_cyc = 1; m0_stb = 1; m0_we = 0; m1_cyc = 1; m1_stb = 1;
      tick();
      for (int k = 0; k < 3; k++) begin
         s_ack = 1; s_rdat = 32'h11 * (k + 1); #1;
         chk($sformatf("t4_m0_dat_%0d", k), m0_rdat, 32'h11 * (k + 1));
         chk($sformatf("t4_grant_%0d", k), 32'(grant), 32'h1);
         chk($sformatf("t4_m1_ack_%0d", k), 32'(m1_ack), 32'h0);
         tick();
      end
      s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
      chk("t4_grant_hold", 32'(grant), 32'h1);
      tick(); #1;
      chk("t4_grant_idle", 32'(grant), 32'h0);
      tick(); #1;
      chk("t4_grant_m1", 32'(grant), 32'h2);
      m1_cyc = 0; m1_stb = 0;
      tick(); tick(); #1;

      // 5: dead slave; abort lands 16 cycles after stb rises
      m0_cyc = 1; m0_stb = 1; m0_we = 0; s_rdat = 32'h1234_5678;
      tick();
      for (int j = 0; j < 16; j++) begin
         #1;
         chk($sformatf("t5_stb_%0d", j), 32'(s_stb), 32'h1);
         chk($sformatf("t5_ack_%0d", j), 32'(m0_ack), 32'h0);
         tick();
      end
      #1;
      chk("t5_abort_stb", 32'(s_stb), 32'h0);
      chk("t5_abort_cyc", 32'(s_cyc), 32'h0);
      chk("t5_abort_ack", 32'(m0_ack), 32'h1);
      chk("t5_abort_dat", m0_rdat, 32'hDEADBEEF);
      chk("t5_abort_m1_ack", 32'(m1_ack), 32'h0);
      chk("t5_tmo_pulse", 32'(tmo), 32'h1);
      chk("t5_abort_grant", 32'(grant), 32'h1);
      m0_cyc = 0; m0_stb = 0;
      tick(); #1;
      chk("t5_tmo_end", 32'(tmo), 32'h0);
      chk("t5_tmo_cnt", 32'(tmo_cnt), 32'h1);
      chk("t5_grant_idle", 32'(grant), 32'h0);

      // 6a: reset in the middle of an m1 cycle
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h000E0030;
      tick(); #1;
      chk("t6_grant_m1", 32'(grant), 32'h2);
      rst = 1;
      tick(); s_ack = 1; #1;
      chk("t6_rst_grant", 32'(grant), 32'h0);
      chk("t6_rst_s_cyc", 32'(s_cyc), 32'h0);
      chk("t6_rst_s_stb", 32'(s_stb), 32'h0);
      chk("t6_rst_s_adr", s_adr, 32'h0);
      chk("t6_rst_m1_ack", 32'(m1_ack), 32'h0);
      chk("t6_rst_tmo_cnt", 32'(tmo_cnt), 32'h0);
      rst = 0; s_ack = 0; m1_cyc = 0; m1_stb = 0;
      tick(); #1;

      // 6b: ack coincides with the watchdog's final cycle
      m0_cyc = 1; m0_stb = 1;
      tick();
      for (int j = 0; j < 15; j++) tick();
      s_ack = 1; s_rdat = 32'hCAFE_0001; #1;
      chk("t6_tie_ack", 32'(m0_ack), 32'h1);
      chk("t6_tie_dat", m0_rdat, 32'hCAFE_0001);
      chk("t6_tie_stb", 32'(s_stb), 32'h1);
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      tick(); #1;
      chk("t6_tie_tmo", 32'(tmo), 32'h0);
      chk("t6_tie_tmo_cnt", 32'(tmo_cnt), 32'h0);
      chk("t6_tie_grant", 32'(grant), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
